// File: rtl/svmrow_mem.sv
// svmrow_mem: streaming linear-SVM row engine for sliding-window detection.
// Captures coefficients during each row's first window, accumulates N overlapping window sums, then unloads them.
module svmrow_mem #(
    parameter int DWIDTH    = 8,
    parameter int CWIDTH    = 9,
    parameter int BLOCKSIZE = 8,
    parameter int WPI       = 8,
    parameter int WINCOLS   = 8,
    parameter int WINROWS   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DWIDTH-1:0]        data,
    input  logic                     dvi_in,
    input  logic                     dvi_bypass,
    input  logic signed [CWIDTH-1:0] svcoeff_in,
    output logic signed [CWIDTH-1:0] svcoeff_out,
    output logic [$clog2(WPI)-1:0]   wincount,
    output logic                     download,
    output logic                     done,
    output logic signed [31:0]       svm_data,
    output logic                     dvo
);
    localparam int W    = BLOCKSIZE * WINCOLS;
    localparam int R    = W * WPI;
    localparam int N    = WPI * WINCOLS;
    localparam int CD   = W * WINROWS;
    localparam int FLEN = R * WINROWS + W;
    localparam int PW   = $clog2(FLEN);
    localparam int CAW  = $clog2(CD);
    localparam int NW   = $clog2(N);
    localparam int WCW  = $clog2(WPI);
    localparam int PRW  = DWIDTH + CWIDTH + 1;

    typedef enum logic [1:0] {
        S_ACCUM,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            p_q, p_d;
    logic [PW-1:0]            row, col;
    logic [NW-1:0]            ucnt_q, ucnt_d;
    logic signed [31:0]       acc_q [N];
    logic signed [31:0]       acc_d [N];
    logic signed [CWIDTH-1:0] cmem_q [CD];
    logic signed [CWIDTH-1:0] svcoeff_q;
    logic                     take;
    logic                     cwe;
    logic [CAW-1:0]           cwaddr;

    logic [PW-1:0]            d;
    logic [PW-1:0]            yy;
    logic [PW-1:0]            xx;
    logic [CAW-1:0]           ca;
    logic signed [CWIDTH-1:0] cf;
    logic signed [PRW-1:0]    prod;

    assign take        = dvi_in && !dvi_bypass && (state_q == S_ACCUM);
    assign row         = p_q / PW'(R);
    assign col         = p_q % PW'(R);
    assign wincount    = WCW'((col / PW'(W)) % PW'(WPI));
    assign cwe         = take && (row < PW'(WINROWS)) && (col < PW'(W));
    assign cwaddr      = CAW'(row * PW'(W) + col);
    assign svcoeff_out = svcoeff_q;

    // Coefficient store, filled during the first window of each of the first WINROWS rows
    always_ff @(posedge clk) begin
        if (cwe) begin
            cmem_q[cwaddr] <= svcoeff_in;
        end
    end

    // Per-sample update of every window covering the current position; clear after unload
    always_comb begin
        d    = '0;
        yy   = '0;
        xx   = '0;
        ca   = '0;
        cf   = '0;
        prod = '0;
        for (int k = 0; k < N; k++) begin
            acc_d[k] = acc_q[k];
        end
        if (state_q == S_DONE) begin
            for (int k = 0; k < N; k++) begin
                acc_d[k] = '0;
            end
        end else if (take) begin
            for (int k = 0; k < N; k++) begin
                if (p_q >= PW'(k * BLOCKSIZE)) begin
                    d  = p_q - PW'(k * BLOCKSIZE);
                    yy = d / PW'(R);
                    xx = d % PW'(R);
                    if ((yy < PW'(WINROWS)) && (xx < PW'(W))) begin
                        ca = CAW'(yy * PW'(W) + xx);
                        // window 0 needs the coefficient arriving with this very pixel
                        cf = (cwe && (ca == cwaddr)) ? svcoeff_in : cmem_q[ca];
                        prod = $signed({1'b0, data}) * cf;
                        acc_d[k] = acc_q[k] + {{(32-PRW){prod[PRW-1]}}, prod};
                    end
                end
            end
        end
    end

    // Frame sequencing: accumulate, unload N sums, pulse done
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        ucnt_d   = ucnt_q;
        download = 1'b0;
        dvo      = 1'b0;
        done     = 1'b0;
        svm_data = '0;
        unique case (state_q)
            S_ACCUM: begin
                if (take) begin
                    if (p_q == PW'(FLEN - 1)) begin
                        p_d     = '0;
                        ucnt_d  = '0;
                        state_d = S_UNLOAD;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
            end
            S_UNLOAD: begin
                download = 1'b1;
                dvo      = 1'b1;
                svm_data = acc_q[ucnt_q];
                ucnt_d   = ucnt_q + 1'b1;
                if (ucnt_q == NW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_ACCUM;
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase
    end

    // State, position, unload counter, accumulators and coefficient chain register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_ACCUM;
            p_q       <= '0;
            ucnt_q    <= '0;
            svcoeff_q <= '0;
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            ucnt_q    <= ucnt_d;
            svcoeff_q <= svcoeff_in;
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end
endmodule

// File: tb/tb_svmrow_mem.sv
// tb_svmrow_mem: directed frames for svmrow_mem.
// Expected window sums come from the direct dot-product formula.
module tb_svmrow_mem;
    localparam int W    = 64;
    localparam int R    = 512;
    localparam int N    = 64;
    localparam int WR   = 16;
    localparam int FLEN = 8256;
    localparam int CD   = 1024;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        data;
    logic              dvi_in;
    logic              dvi_bypass;
    logic signed [8:0] svcoeff_in;
    logic signed [8:0] svcoeff_out;
    logic [2:0]        wincount;
    logic              download;
    logic              done;
    logic signed [31:0] svm_data;
    logic              dvo;

    int checks   = 0;
    int failures = 0;
    int dmem [FLEN];
    int cmem [CD];
    int exp_s [N];

    svmrow_mem dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data        (data),
        .dvi_in      (dvi_in),
        .dvi_bypass  (dvi_bypass),
        .svcoeff_in  (svcoeff_in),
        .svcoeff_out (svcoeff_out),
        .wincount    (wincount),
        .download    (download),
        .done        (done),
        .svm_data    (svm_data),
        .dvo         (dvo)
    );

    always #5 clk = ~clk;

    task automatic fill(input int mode);
        longint s;
        for (int p = 0; p < FLEN; p++) begin
            case (mode)
                0: dmem[p] = 1;
                1: dmem[p] = 255;
                2: dmem[p] = (p == 0) ? 10 : 0;
                3: dmem[p] = p % 100;
                default: dmem[p] = int'($urandom_range(0, 99));
            endcase
        end
        for (int a = 0; a < CD; a++) begin
            case (mode)
                0: cmem[a] = 1;
                1: cmem[a] = -256;
                2: cmem[a] = 3;
                3: cmem[a] = (a == 0) ? 5 : 0;
                default: cmem[a] = int'($urandom_range(0, 198)) - 99;
            endcase
        end
        for (int k = 0; k < N; k++) begin
            s = 0;
            for (int y = 0; y < WR; y++) begin
                for (int x = 0; x < W; x++) begin
                    s += longint'(dmem[k*8 + y*R + x]) * longint'(cmem[y*W + x]);
                end
            end
            exp_s[k] = int'(s);
        end
    endtask

    task automatic stream(input int nsamp, input bit gaps);
        for (int p = 0; p < nsamp; p++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    data       = 8'($urandom);
                    svcoeff_in = 9'($urandom);
                    dvi_in     = 1'($urandom_range(0, 1));
                    dvi_bypass = dvi_in;
                end
            end
            @(negedge clk);
            if (p % 64 == 0) begin
                checks++;
                if (wincount !== 3'(((p % R) / W) % 8)) begin
                    failures++;
                    $display("FAIL wincount_p%0d: got %0d, required %0d",
                             p, wincount, ((p % R) / W) % 8);
                end
            end
            data = 8'(dmem[p]);
            if ((p / R < WR) && (p % R < W)) begin
                svcoeff_in = 9'(cmem[(p / R) * W + p % R]);
            end else begin
                svcoeff_in = gaps ? 9'($urandom) : -9'sd100;
            end
            dvi_in     = 1'b1;
            dvi_bypass = 1'b0;
        end
        @(negedge clk);
        dvi_in     = 1'b0;
        dvi_bypass = 1'b0;
    endtask

    task automatic check_burst(input string tag, input bit junk);
        int lat = 0;
        while (dvo !== 1'b1 && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (dvo !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency: dvo=%b after %0d cycles, required 1", tag, dvo, lat);
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (junk) begin
                dvi_in = 1'b1;
                data   = 8'd99;
            end
            checks++;
            if (dvo !== 1'b1 || download !== 1'b1 || svm_data !== exp_s[i]) begin
                failures++;
                $display("FAIL %s_sum%0d: dvo=%b download=%b svm_data=%0d, required 1 1 %0d",
                         tag, i, dvo, download, svm_data, exp_s[i]);
            end
            @(negedge clk);
        end
        dvi_in = 1'b0;
        checks++;
        if (dvo !== 1'b0 || download !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: dvo=%b download=%b done=%b, required 0 0 1",
                     tag, dvo, download, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dvo !== 1'b0 || wincount !== 3'd0) begin
            failures++;
            $display("FAIL %s_after: done=%b dvo=%b wincount=%0d, required 0 0 0",
                     tag, done, dvo, wincount);
        end
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        data       = '0;
        dvi_in     = 1'b0;
        dvi_bypass = 1'b0;
        svcoeff_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (dvo !== 1'b0 || download !== 1'b0 || done !== 1'b0 ||
            svm_data !== 32'sd0 || wincount !== 3'd0 || svcoeff_out !== 9'sd0) begin
            failures++;
            $display("FAIL reset_outputs: dvo=%b dl=%b done=%b data=%0d wc=%0d co=%0d, required all 0",
                     dvo, download, done, svm_data, wincount, svcoeff_out);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dvo !== 1'b0 || done !== 1'b0 || wincount !== 3'd0) begin
            failures++;
            $display("FAIL reset_release: dvo=%b done=%b wc=%0d, required 0 0 0",
                     dvo, done, wincount);
        end
    endtask

    task automatic test_chain;
        svcoeff_in = -9'sd77;
        @(negedge clk);
        checks++;
        if (svcoeff_out !== -9'sd77) begin
            failures++;
            $display("FAIL chain_neg: got %0d, required -77", svcoeff_out);
        end
        svcoeff_in = 9'sd123;
        @(negedge clk);
        checks++;
        if (svcoeff_out !== 9'sd123) begin
            failures++;
            $display("FAIL chain_pos: got %0d, required 123", svcoeff_out);
        end
    endtask

    task automatic test_all_ones;
        fill(0);
        stream(FLEN, 1'b0);
        check_burst("ones", 1'b0);
    endtask

    task automatic test_negative;
        fill(1);
        stream(FLEN, 1'b0);
        check_burst("neg", 1'b0);
    endtask

    task automatic test_single;
        fill(2);
        stream(FLEN, 1'b0);
        check_burst("single", 1'b0);
    endtask

    task automatic test_back_to_back;
        fill(3);
        stream(FLEN, 1'b0);
        check_burst("b2b", 1'b0);
    endtask

    task automatic test_random_gaps;
        fill(4);
        stream(FLEN, 1'b1);
        check_burst("rand", 1'b1);
    endtask

    task automatic test_reset_mid;
        fill(1);
        stream(3000, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dvo !== 1'b0 || done !== 1'b0 || wincount !== 3'd0) begin
            failures++;
            $display("FAIL midreset_state: dvo=%b done=%b wc=%0d, required 0 0 0",
                     dvo, done, wincount);
        end
        reset_n = 1'b1;
        @(negedge clk);
        fill(0);
        stream(FLEN, 1'b0);
        check_burst("midreset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_chain();
        test_all_ones();
        test_negative();
        test_single();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
